// File: rtl/up_down_count_decoder.sv
// up_down_count_decoder: recovers counting direction from a sampled up/down count stream and flags illegal jumps
module up_down_count_decoder #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] count_in,
  output logic             mode,
  output logic             locked,
  output logic             step_up,
  output logic             step_down,
  output logic             dir_change,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);
  typedef enum logic [1:0] {EMPTY, ACQ, LOCKED} state_t;
  state_t state;
  logic [WIDTH-1:0] prev, delta;
  logic [3:0] run_cnt, run_next;
  logic run_dir, is_up, is_dn, is_jump;
  logic [ERR_W-1:0] err_sat;
  // Modular difference makes 15->0 an up step and 0->15 a down step
  assign delta    = count_in - prev;
  assign is_up    = delta == WIDTH'(1);
  assign is_dn    = delta == '1;
  assign is_jump  = !is_up && !is_dn && delta != '0;
  assign run_next = (run_cnt == 4'd0 || is_up == run_dir) ? run_cnt + 4'd1 : 4'd1;
  assign err_sat  = err_cnt + ERR_W'(err_cnt != '1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      prev       <= '0;
      run_cnt    <= '0;
      run_dir    <= 1'b0;
      mode       <= 1'b0;
      locked     <= 1'b0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      dir_change <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      dir_change <= 1'b0;
      err        <= 1'b0;
      if (in_valid) begin
        prev <= count_in;
        case (state)
          EMPTY: begin
            state   <= ACQ;
            run_cnt <= '0;
          end
          ACQ: begin
            if (is_up || is_dn) begin
              step_up   <= is_up;
              step_down <= is_dn;
              run_cnt   <= run_next;
              run_dir   <= is_up;
              if (run_next == 4'(LOCK_N)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                mode   <= is_up;
              end
            end else if (is_jump) begin
              err     <= 1'b1;
              err_cnt <= err_sat;
              run_cnt <= '0;
            end
          end
          LOCKED: begin
            if (is_up || is_dn) begin
              step_up    <= is_up;
              step_down  <= is_dn;
              dir_change <= is_up != mode;
              mode       <= is_up;
            end else if (is_jump) begin
              err     <= 1'b1;
              err_cnt <= err_sat;
              locked  <= 1'b0;
              state   <= ACQ;
              run_cnt <= '0;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end
endmodule
